// File: rtl/square_root_csa_pkg.sv
// Shared constants for the square-root carry-select adder.
// Holds the operand width default, the block count and the LSB-to-MSB
// block size / start-offset tables. The tables describe a 32-bit operand.
package square_root_csa_pkg;

  localparam int SQRT_WIDTH = 32;
  localparam int BLK_COUNT  = 8;

  // Block sizes grow by one per block so that each block's local ripple
  // finishes at about the time its select carry arrives; the last block is
  // whatever remains of the 32 bits.
  localparam int BLK_SIZE [BLK_COUNT] = '{2, 2, 3, 4, 5, 6, 7, 3};
  localparam int BLK_OFS  [BLK_COUNT] = '{0, 2, 4, 7, 11, 16, 22, 29};

  // Single-bit full-adder sum and carry, shared by the ripple blocks.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/square_root_csa_rca_block.sv
// rca_block: N-bit ripple-carry adder built from full-adder equations.
// Ports:
//   i_a, i_b : N-bit addends
//   i_cin    : carry-in
//   o_sum    : N-bit sum
//   o_cout   : carry-out of the top bit
module rca_block
  import square_root_csa_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_sum[i]  = fa_sum(i_a[i], i_b[i], w_c[i]);
    assign w_c[i+1]  = fa_carry(i_a[i], i_b[i], w_c[i]);
  end

  assign o_cout = w_c[N];

endmodule

// File: rtl/square_root_csa.sv
// square_root_csa: registered unsigned adder sout = in1 + in2 + c0 built as a
// square-root carry-select adder (blocks 2,2,3,4,5,6,7,3 from the LSB).
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset, clears sout
//   in1  : WIDTH-bit addend A (unsigned)
//   in2  : WIDTH-bit addend B (unsigned)
//   c0   : carry-in
//   sout : WIDTH+1-bit registered sum, bit WIDTH is the carry-out
// The block tables in the package cover WIDTH = 32 only.
module square_root_csa
  import square_root_csa_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c0,
  output logic [WIDTH:0]   sout
);

  // Block 0 result
  logic [1:0]           w_lo_sum;
  logic                 w_lo_cout;
  // Speculative results of blocks 1..7 for carry-in 0 and carry-in 1
  logic [WIDTH-1:2]     w_sum0;
  logic [WIDTH-1:2]     w_sum1;
  logic [BLK_COUNT-1:1] w_cout0;
  logic [BLK_COUNT-1:1] w_cout1;
  // Selected result
  logic [WIDTH-1:0]     w_sum;
  logic                 w_chain;
  logic [WIDTH:0]       r_sout;

  rca_block #(.N(BLK_SIZE[0])) u_blk0 (
    .i_a   (in1[BLK_OFS[0] +: BLK_SIZE[0]]),
    .i_b   (in2[BLK_OFS[0] +: BLK_SIZE[0]]),
    .i_cin (c0),
    .o_sum (w_lo_sum),
    .o_cout(w_lo_cout)
  );

  for (genvar b = 1; b < BLK_COUNT; b++) begin : g_blk
    localparam int N = BLK_SIZE[b];
    localparam int O = BLK_OFS[b];

    rca_block #(.N(N)) u_rca0 (
      .i_a   (in1[O +: N]),
      .i_b   (in2[O +: N]),
      .i_cin (1'b0),
      .o_sum (w_sum0[O +: N]),
      .o_cout(w_cout0[b])
    );

    rca_block #(.N(N)) u_rca1 (
      .i_a   (in1[O +: N]),
      .i_b   (in2[O +: N]),
      .i_cin (1'b1),
      .o_sum (w_sum1[O +: N]),
      .o_cout(w_cout1[b])
    );
  end

  // Carry-select chain: the incoming carry picks each block's sum bits and
  // its carry-out, one 2:1 mux per block on the carry path.
  always_comb begin
    w_sum   = {WIDTH{1'b0}};
    w_chain = w_lo_cout;
    w_sum[1:0] = w_lo_sum;
    for (int b = 1; b < BLK_COUNT; b++) begin
      for (int k = 0; k < BLK_SIZE[b]; k++) begin
        w_sum[BLK_OFS[b] + k] = w_chain ? w_sum1[BLK_OFS[b] + k]
                                        : w_sum0[BLK_OFS[b] + k];
      end
      w_chain = w_chain ? w_cout1[b] : w_cout0[b];
    end
  end

  // Output register: captures the full sum every cycle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sout <= {(WIDTH+1){1'b0}};
    end else begin
      r_sout <= {w_chain, w_sum};
    end
  end

  assign sout = r_sout;

endmodule

// File: tb/tb_square_root_csa.sv
// Self-checking bench for square_root_csa: directed vectors with
// hand-computed results plus a back-to-back random regression.
module tb_square_root_csa;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         c0;
  logic [W:0]   sout;

  int checks;
  int errors;

  square_root_csa #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .c0  (c0),
    .sout(sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operand set, clock it in and compare one edge later.
  task automatic apply_and_check(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c,
                                 input logic [W:0] expected);
    in1 = a;
    in2 = b;
    c0  = c;
    @(posedge clk);
    #1;
    checks++;
    if (sout !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, sout, expected);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in1 = 32'hFFFF_FFFF;
    in2 = 32'h0000_0001;
    c0  = 1'b1;
    #1;
    checks++;
    if (sout !== 33'h0_0000_0000) begin
      errors++;
      $display("FAIL reset_before_edge: got 0x%09h expected 0x000000000", sout);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sout !== 33'h0_0000_0000) begin
      errors++;
      $display("FAIL reset_after_edges: got 0x%09h expected 0x000000000", sout);
    end
    @(negedge clk);
    rst = 1'b0;
    // First edge after release loads FFFFFFFF + 1 + 1.
    @(posedge clk);
    #1;
    checks++;
    if (sout !== 33'h1_0000_0001) begin
      errors++;
      $display("FAIL reset_first_load: got 0x%09h expected 0x100000001", sout);
    end
  endtask

  task automatic test_basic();
    apply_and_check("basic_5_3_1", 32'h0000_0005, 32'h0000_0003, 1'b1, 33'h0_0000_0009);
    apply_and_check("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    apply_and_check("pattern", 32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
    apply_and_check("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
  endtask

  task automatic test_carry_chain();
    apply_and_check("full_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    apply_and_check("maximum", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    apply_and_check("max_no_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
  endtask

  task automatic test_block_boundary();
    apply_and_check("boundary_b29", 32'h2000_0000, 32'h6000_0000, 1'b0, 33'h0_8000_0000);
    apply_and_check("boundary_b11", 32'h0000_07FF, 32'h0000_0001, 1'b0, 33'h0_0000_0800);
    apply_and_check("boundary_b2", 32'h0000_0003, 32'h0000_0000, 1'b1, 33'h0_0000_0004);
    apply_and_check("boundary_b22", 32'h003F_FFFF, 32'h0000_0000, 1'b1, 33'h0_0040_0000);
    apply_and_check("boundary_b16", 32'h0000_8000, 32'h0000_8000, 1'b0, 33'h0_0001_0000);
  endtask

  task automatic test_reset_mid();
    apply_and_check("pre_mid_reset", 32'h0000_1000, 32'h0000_0234, 1'b0, 33'h0_0000_1234);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sout !== 33'h0_0000_0000) begin
      errors++;
      $display("FAIL mid_reset_clear: got 0x%09h expected 0x000000000", sout);
    end
    in1 = 32'h0000_00F0;
    in2 = 32'h0000_000F;
    c0  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sout !== 33'h0_0000_0100) begin
      errors++;
      $display("FAIL mid_reset_reload: got 0x%09h expected 0x000000100", sout);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   expected;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom();
      b = $urandom();
      c = 1'($urandom_range(1, 0));
      expected = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      in1 = a;
      in2 = b;
      c0  = c;
      @(posedge clk);
      #1;
      checks++;
      if (sout !== expected) begin
        errors++;
        $display("FAIL random[%0d]: got 0x%09h expected 0x%09h", i, sout, expected);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in1 = 32'h0000_0000;
    in2 = 32'h0000_0000;
    c0  = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_block_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
